multi_one_shot: RTL and testbench

Parametrised multi-channel monostable (one-shot) pulse generator. Each channel converts a rising edge on its trigger input into an output pulse. The pulse width is programmable at run time and is captured when the trigger is accepted. Each channel supports a retriggerable or non-retriggerable mode, a post-pulse holdoff window, and done/ignored status strobes. The block sits between asynchronous-ish control events (already synchronised upstream) and downstream logic that needs fixed-length enables.

---
 rtl/multi_one_shot_if.sv | 23 ++
 rtl/multi_one_shot.sv | 101 ++++++++++
 tb/tb_multi_one_shot.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/multi_one_shot_if.sv
// rtl/multi_one_shot_if.sv - trigger/config/status bundle for the multi-channel one-shot
interface multi_one_shot_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
);
  logic [CHANNELS-1:0] trigger;
  logic [CNT_W-1:0]    cfg_width;
  logic                cfg_retrig;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] done;
  logic [CHANNELS-1:0] ignored;

  modport master (
    output trigger, cfg_width, cfg_retrig,
    input  out, busy, done, ignored
  );

  modport slave (
    input  trigger, cfg_width, cfg_retrig,
    output out, busy, done, ignored
  );
endinterface

// File: rtl/multi_one_shot.sv
// rtl/multi_one_shot.sv - multi-channel monostable with retrigger, holdoff and status strobes
module multi_one_shot #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int HOLDOFF  = 0
) (
  input logic            clk,
  input logic            rst_n,
  multi_one_shot_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] HOLD_M1 = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

  // Width 0 is clamped to 1, so the reload value is never negative.
  logic [CNT_W-1:0] w_width_m1;
  assign w_width_m1 = (bus.cfg_width == '0) ? '0 : bus.cfg_width - CNT_W'(1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_trig_q;
    logic             r_out;
    logic             r_busy;
    logic             r_done;
    logic             r_ignored;
    logic             w_edge;

    assign w_edge = bus.trigger[g] & ~r_trig_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_hcnt    <= '0;
        r_trig_q  <= 1'b0;
        r_out     <= 1'b0;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
        r_ignored <= 1'b0;
      end else begin
        r_trig_q  <= bus.trigger[g];
        r_done    <= 1'b0;
        r_ignored <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_edge) begin
              r_cnt   <= w_width_m1;
              r_out   <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= S_ACTIVE;
            end
          end
          S_ACTIVE: begin
            // A retrigger edge beats the terminal count, so no done is lost or doubled.
            if (w_edge && bus.cfg_retrig) begin
              r_cnt <= w_width_m1;
            end else begin
              if (w_edge) begin
                r_ignored <= 1'b1;
              end
              if (r_cnt == '0) begin
                r_out  <= 1'b0;
                r_done <= 1'b1;
                if (HOLDOFF > 0) begin
                  r_hcnt  <= HOLD_M1;
                  r_state <= S_HOLD;
                end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end
              end else begin
                r_cnt <= r_cnt - CNT_W'(1);
              end
            end
          end
          S_HOLD: begin
            if (w_edge) begin
              r_ignored <= 1'b1;
            end
            if (r_hcnt == '0) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_hcnt <= r_hcnt - CNT_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign bus.out[g]     = r_out;
    assign bus.busy[g]    = r_busy;
    assign bus.done[g]    = r_done;
    assign bus.ignored[g] = r_ignored;
  end

endmodule

// File: tb/tb_multi_one_shot.sv
// tb/tb_multi_one_shot.sv - directed bench for multi_one_shot (HOLDOFF=3 and HOLDOFF=0 instances)
module tb_multi_one_shot;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] trig;
  logic [7:0] width;
  logic       retrig;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  multi_one_shot_if #(.CHANNELS(4), .CNT_W(8)) ifa ();
  multi_one_shot_if #(.CHANNELS(4), .CNT_W(8)) ifb ();

  assign ifa.trigger    = trig;
  assign ifa.cfg_width  = width;
  assign ifa.cfg_retrig = retrig;
  assign ifb.trigger    = trig;
  assign ifb.cfg_width  = width;
  assign ifb.cfg_retrig = retrig;

  multi_one_shot #(.CHANNELS(4), .CNT_W(8), .HOLDOFF(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  multi_one_shot #(.CHANNELS(4), .CNT_W(8), .HOLDOFF(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic [15:0] obs_a;
  logic [15:0] obs_b;
  assign obs_a = {ifa.out, ifa.busy, ifa.done, ifa.ignored};
  assign obs_b = {ifb.out, ifb.busy, ifb.done, ifb.ignored};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] sh(input logic b, input int ch);
    return b ? (4'b0001 << ch) : 4'b0000;
  endfunction

  function automatic logic [15:0] pack(input logic o, b, d, i, input int ch);
    return {sh(o, ch), sh(b, ch), sh(d, ch), sh(i, ch)};
  endfunction

  task automatic idle(input int n);
    trig = '0;
    repeat (n) @(negedge clk);
  endtask

  // tp[k]: trigger level presented for edge k; op/bp/dp/ip[s]: expected value sampled s cycles later
  task automatic scan(input string tag, input bit use_b, input int ch, input int n,
                      input logic [63:0] tp, op, bp, dp, ip);
    for (int k = 0; k < n; k++) begin
      trig[ch] = tp[k];
      @(negedge clk);
      check_eq($sformatf("%s s%0d", tag, k + 1),
               32'(use_b ? obs_b : obs_a),
               32'(pack(op[k+1], bp[k+1], dp[k+1], ip[k+1], ch)));
    end
    trig[ch] = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    trig   = '0;
    width  = 8'd5;
    retrig = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_a", 32'(obs_a), 32'h0);
    check_eq("reset_b", 32'(obs_b), 32'h0);
    rst_n = 1'b1;
    idle(2);

    scan("single", 0, 0, 10, rng(0,0), rng(1,5), rng(1,8), rng(6,6), '0);
    idle(6);

    retrig = 1'b1;
    scan("retrig", 0, 0, 12, rng(0,0) | rng(3,3), rng(1,8), rng(1,11), rng(9,9), '0);
    idle(6);
    scan("retrig_cnt0", 0, 0, 14, rng(0,0) | rng(5,5), rng(1,10), rng(1,13), rng(11,11), '0);
    idle(6);

    retrig = 1'b0;
    scan("noretrig", 0, 0, 10, rng(0,0) | rng(3,3), rng(1,5), rng(1,8), rng(6,6), rng(4,4));
    idle(6);

    width = 8'd2;
    scan("holdoff", 0, 0, 12, rng(0,0) | rng(4,4) | rng(6,6),
         rng(1,2) | rng(7,8), rng(1,5) | rng(7,11), rng(3,3) | rng(9,9), rng(5,5));
    idle(6);
    scan("hold_last", 0, 0, 8, rng(0,0) | rng(5,5), rng(1,2), rng(1,5), rng(3,3), rng(6,6));
    idle(6);
    scan("holdoff0", 1, 0, 8, rng(0,0) | rng(3,3),
         rng(1,2) | rng(4,5), rng(1,2) | rng(4,5), rng(3,3) | rng(6,6), '0);
    idle(8);

    width = 8'd0;
    scan("width0", 0, 3, 6, rng(0,0), rng(1,1), rng(1,4), rng(2,2), '0);
    idle(6);

    width = 8'd5;
    scan("held50", 0, 1, 58, rng(0,49), rng(1,5), rng(1,8), rng(6,6), '0);
    idle(6);

    width = 8'd255;
    for (int k = 0; k < 260; k++) begin
      trig[0] = (k == 0);
      @(negedge clk);
      check_eq($sformatf("w255 s%0d", k + 1), 32'(obs_a),
               32'(pack((k + 1) <= 255, (k + 1) <= 258, (k + 1) == 256, 1'b0, 0)));
    end
    idle(6);

    // Two pairs of channels captured with different widths two cycles apart.
    for (int k = 0; k < 13; k++) begin
      logic [3:0] eo, eb, ed;
      int s;
      s = k + 1;
      if (k == 0) begin trig = 4'b0011; width = 8'd3; end
      else if (k == 2) begin trig = 4'b1100; width = 8'd7; end
      else trig = 4'b0000;
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        eo[c] = (c < 2) ? (s >= 1 && s <= 3) : (s >= 3 && s <= 9);
        eb[c] = (c < 2) ? (s >= 1 && s <= 6) : (s >= 3 && s <= 12);
        ed[c] = (c < 2) ? (s == 4) : (s == 10);
      end
      check_eq($sformatf("concur s%0d", s), 32'(obs_a), 32'({eo, eb, ed, 4'b0000}));
    end
    idle(6);

    width = 8'd7;
    trig  = 4'b1111;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_out", 32'(ifa.out), 32'h0000000f);
    trig  = 4'b0100;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_reset_a", 32'(obs_a), 32'h0);
    check_eq("mid_reset_b", 32'(obs_b), 32'h0);
    @(negedge clk);
    check_eq("mid_reset_a2", 32'(obs_a), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check_eq($sformatf("post_reset s%0d", k + 1), 32'(obs_a),
               32'(pack((k + 1) <= 7, (k + 1) <= 10, (k + 1) == 8, 1'b0, 2)));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
